// File: rtl/icebus_status_rx.sv
// IceBus status receiver: turns a UART byte stream of 16-byte motor status frames
// into CRC-checked, id-checked status outputs with event pulses and saturating counters.
module icebus_status_rx #(
  parameter int CLOCK_FREQ_HZ    = 50_000_000,
  parameter int BAUDRATE         = 1_000_000,
  parameter int NUMBER_OF_MOTORS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_i,
  output logic               status_valid,
  output logic [7:0]         status_motor,
  output logic signed [23:0] encoder0_position,
  output logic signed [23:0] encoder1_position,
  output logic signed [23:0] displacement,
  output logic signed [12:0] current,
  output logic               crc_error,
  output logic               id_error,
  output logic               framing_error,
  output logic               timeout_error,
  output logic [31:0]        frame_count,
  output logic [31:0]        crc_error_count
);

  localparam int          DIV          = CLOCK_FREQ_HZ / BAUDRATE;
  localparam int          HALF         = DIV / 2;
  localparam logic [15:0] BIT_LAST     = 16'(DIV - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(40 * DIV - 1);
  localparam logic [31:0] NUM_MOTORS_U = 32'(NUMBER_OF_MOTORS);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [2:0] {HUNT0, HUNT1, PAYLOAD, CRC, CHECK} parse_state_t;

  logic         rx_meta, rx_sync, rx_prev;
  rx_state_t    rx_state, rx_next;
  logic [15:0]  baud_cnt;
  logic         baud_done;
  logic [2:0]   bit_idx;
  logic [7:0]   rx_shift, rx_byte;
  logic         byte_strobe;

  parse_state_t p_state, p_next;
  logic [3:0]   byte_idx;
  logic [15:0]  crc_reg, rx_crc;
  logic [95:0]  shadow;
  logic [31:0]  idle_cnt;
  logic         timeout_hit;
  logic         id_ok;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Synchronizer plus one extra stage for falling-edge detection; all idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign baud_done = (rx_state == RX_START) ? (baud_cnt == HALF_LAST) : (baud_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START:     if (baud_done) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:      if (baud_done && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (baud_done) rx_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt      <= '0;
      bit_idx       <= '0;
      rx_shift      <= '0;
      rx_byte       <= '0;
      byte_strobe   <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      byte_strobe   <= 1'b0;
      framing_error <= 1'b0;
      if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH || baud_done) baud_cnt <= '0;
      else                                                              baud_cnt <= baud_cnt + 16'd1;
      if (rx_state == RX_START) bit_idx <= '0;
      if (rx_state == RX_DATA && baud_done) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && baud_done) begin
        if (rx_sync) begin
          byte_strobe <= 1'b1;
          rx_byte     <= rx_shift;
        end else begin
          framing_error <= 1'b1;
        end
      end
    end
  end

  assign timeout_hit = (p_state == PAYLOAD || p_state == CRC) && !byte_strobe && idle_cnt == TIMEOUT_LAST;
  assign id_ok       = shadow[95] && ({25'd0, shadow[94:88]} < NUM_MOTORS_U);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_state <= HUNT0;
    else       p_state <= p_next;
  end

  // Line faults take priority over whatever the byte stream would do next.
  always_comb begin
    p_next = p_state;
    if (framing_error || timeout_hit) begin
      p_next = HUNT0;
    end else begin
      case (p_state)
        HUNT0:   if (byte_strobe && rx_byte == 8'hAA) p_next = HUNT1;
        HUNT1:   if (byte_strobe) begin
                   if (rx_byte == 8'h55)      p_next = PAYLOAD;
                   else if (rx_byte != 8'hAA) p_next = HUNT0;
                 end
        PAYLOAD: if (byte_strobe && byte_idx == 4'd11) p_next = CRC;
        CRC:     if (byte_strobe && byte_idx == 4'd1) p_next = CHECK;
        CHECK:   p_next = HUNT0;
        default: p_next = HUNT0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx          <= '0;
      crc_reg           <= 16'hFFFF;
      rx_crc            <= '0;
      shadow            <= '0;
      idle_cnt          <= '0;
      status_valid      <= 1'b0;
      status_motor      <= '0;
      encoder0_position <= '0;
      encoder1_position <= '0;
      displacement      <= '0;
      current           <= '0;
      crc_error         <= 1'b0;
      id_error          <= 1'b0;
      timeout_error     <= 1'b0;
      frame_count       <= '0;
      crc_error_count   <= '0;
    end else begin
      status_valid  <= 1'b0;
      crc_error     <= 1'b0;
      id_error      <= 1'b0;
      timeout_error <= timeout_hit;

      if ((p_state != PAYLOAD && p_state != CRC) || byte_strobe) idle_cnt <= '0;
      else                                                       idle_cnt <= idle_cnt + 32'd1;

      if (p_state == HUNT1 && byte_strobe && rx_byte == 8'h55) begin
        byte_idx <= '0;
        crc_reg  <= 16'hFFFF;
      end
      if (p_state == PAYLOAD && byte_strobe) begin
        shadow   <= {shadow[87:0], rx_byte};
        crc_reg  <= crc16_step(crc_reg, rx_byte);
        byte_idx <= (byte_idx == 4'd11) ? 4'd0 : byte_idx + 4'd1;
      end
      if (p_state == CRC && byte_strobe) begin
        rx_crc   <= {rx_crc[7:0], rx_byte};
        byte_idx <= byte_idx + 4'd1;
      end

      // Shadow fields reach the outputs only for a frame that passes both checks.
      if (p_state == CHECK) begin
        if (crc_reg != rx_crc) begin
          crc_error <= 1'b1;
          if (crc_error_count != 32'hFFFF_FFFF) crc_error_count <= crc_error_count + 32'd1;
        end else if (!id_ok) begin
          id_error <= 1'b1;
        end else begin
          status_valid      <= 1'b1;
          status_motor      <= {1'b0, shadow[94:88]};
          encoder0_position <= shadow[87:64];
          encoder1_position <= shadow[63:40];
          displacement      <= shadow[39:16];
          current           <= shadow[12:0];
          if (frame_count != 32'hFFFF_FFFF) frame_count <= frame_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_icebus_status_rx.sv
// Self-checking bench for icebus_status_rx: UART frame driver, expected-event scoreboard,
// table of frame vectors plus hand-written timeout, framing, reset and latency sequences.
module tb_icebus_status_rx;

  localparam int DIV = 8;
  localparam int EV_VALID = 0, EV_CRC = 1, EV_ID = 2, EV_TIMEOUT = 3, EV_FRAMING = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               rx;
  logic               status_valid;
  logic [7:0]         status_motor;
  logic signed [23:0] encoder0_position, encoder1_position, displacement;
  logic signed [12:0] current;
  logic               crc_error, id_error, framing_error, timeout_error;
  logic [31:0]        frame_count, crc_error_count;

  icebus_status_rx #(
    .CLOCK_FREQ_HZ(8_000_000),
    .BAUDRATE(1_000_000),
    .NUMBER_OF_MOTORS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_i(rx),
    .status_valid(status_valid),
    .status_motor(status_motor),
    .encoder0_position(encoder0_position),
    .encoder1_position(encoder1_position),
    .displacement(displacement),
    .current(current),
    .crc_error(crc_error),
    .id_error(id_error),
    .framing_error(framing_error),
    .timeout_error(timeout_error),
    .frame_count(frame_count),
    .crc_error_count(crc_error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [7:0]  motor;
    logic [23:0] e0, e1, d;
    logic [12:0] cur;
    logic [31:0] fc, cc;
  } exp_t;

  typedef struct {
    logic [7:0]  id;
    logic [23:0] e0, e1, d;
    logic [15:0] cur;
    logic [7:0]  crc_x;
    bit          pre_aa;
    int          kind;
  } vec_t;

  exp_t sb[$];
  exp_t model;
  exp_t mon_e;
  int   mon_kind;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   byte_start_cyc = 0;
  int   last_valid_cyc = -1;
  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crcModel(input logic [95:0] msg);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 95; k >= 0; k--) begin
      fb = c[15] ^ msg[k];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic sendByte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    byte_start_cyc = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_ok;
    repeat (DIV) @(negedge clk);
    if (!stop_ok) begin
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] id, input logic [23:0] e0, input logic [23:0] e1,
                           input logic [23:0] d, input logic [15:0] cur, input logic [7:0] crc_x);
    logic [95:0] body;
    logic [15:0] c;
    body = {id, e0, e1, d, cur};
    c = crcModel(body);
    sendByte(8'hAA, 1'b1);
    sendByte(8'h55, 1'b1);
    for (int i = 0; i < 12; i++) sendByte(body[95 - 8 * i -: 8], 1'b1);
    sendByte(c[15:8], 1'b1);
    sendByte(c[7:0] ^ crc_x, 1'b1);
  endtask

  task automatic pushExpect(input int kind);
    exp_t e;
    e = model;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.kind == EV_VALID) begin
      model.motor = v.id - 8'd128;
      model.e0    = v.e0;
      model.e1    = v.e1;
      model.d     = v.d;
      model.cur   = v.cur[12:0];
      model.fc    = model.fc + 1;
    end else if (v.kind == EV_CRC) begin
      model.cc = model.cc + 1;
    end
    pushExpect(v.kind);
    if (v.pre_aa) sendByte(8'hAA, 1'b1);
    sendFrame(v.id, v.e0, v.e1, v.d, v.cur, v.crc_x);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    repeat (2 * DIV) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic checkAllZero();
    checkOutput("rst_status_valid", {31'd0, status_valid}, 32'd0);
    checkOutput("rst_status_motor", {24'd0, status_motor}, 32'd0);
    checkOutput("rst_encoder0", {8'd0, encoder0_position}, 32'd0);
    checkOutput("rst_encoder1", {8'd0, encoder1_position}, 32'd0);
    checkOutput("rst_displacement", {8'd0, displacement}, 32'd0);
    checkOutput("rst_current", {19'd0, current}, 32'd0);
    checkOutput("rst_error_pulses", {28'd0, crc_error, id_error, framing_error, timeout_error}, 32'd0);
    checkOutput("rst_frame_count", frame_count, 32'd0);
    checkOutput("rst_crc_error_count", crc_error_count, 32'd0);
  endtask

  // Every event pulse must match the oldest expectation, including untouched status fields.
  always @(negedge clk) begin
    if (!reset && (status_valid || crc_error || id_error || timeout_error || framing_error)) begin
      mon_kind = status_valid ? EV_VALID : crc_error ? EV_CRC : id_error ? EV_ID :
                 timeout_error ? EV_TIMEOUT : EV_FRAMING;
      if (status_valid) last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_event actual_kind=%0d required=none", mon_kind);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("event_kind", 32'(mon_kind), 32'(mon_e.kind));
        checkOutput("status_motor", {24'd0, status_motor}, {24'd0, mon_e.motor});
        checkOutput("encoder0_position", {8'd0, encoder0_position}, {8'd0, mon_e.e0});
        checkOutput("encoder1_position", {8'd0, encoder1_position}, {8'd0, mon_e.e1});
        checkOutput("displacement", {8'd0, displacement}, {8'd0, mon_e.d});
        checkOutput("current", {19'd0, current}, {19'd0, mon_e.cur});
        checkOutput("frame_count", frame_count, mon_e.fc);
        checkOutput("crc_error_count", crc_error_count, mon_e.cc);
      end
    end
  end

  initial begin
    #800_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h83, 24'h000100, 24'hFFFFFE, 24'h000010, 16'h1FFF, 8'h00, 1'b0, EV_VALID};
    vecs[1] = '{8'h83, 24'h000100, 24'hFFFFFE, 24'h000010, 16'h1FFF, 8'h01, 1'b0, EV_CRC};
    vecs[2] = '{8'h80, 24'h123456, 24'h800000, 24'h7FFFFF, 16'hE123, 8'h00, 1'b1, EV_VALID};
    vecs[3] = '{8'h7F, 24'h111111, 24'h222222, 24'h333333, 16'h0444, 8'h00, 1'b0, EV_ID};
    vecs[4] = '{8'h88, 24'h555555, 24'h666666, 24'h777777, 16'h0888, 8'h00, 1'b0, EV_ID};
    vecs[5] = '{8'h87, 24'hABCDEF, 24'h000001, 24'hFEDCBA, 16'h1000, 8'h00, 1'b0, EV_VALID};
    vecs[6] = '{8'h81, 24'h010203, 24'h040506, 24'h070809, 16'h0A0B, 8'h80, 1'b0, EV_CRC};
    model = '{EV_VALID, 8'd0, 24'd0, 24'd0, 24'd0, 13'd0, 32'd0, 32'd0};

    reset = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checkAllZero();
    reset = 1'b0;
    repeat (4 * DIV) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      waitDrain(6 * DIV);
      if (i == 0) begin
        checks++;
        if (last_valid_cyc - byte_start_cyc < 9 * DIV + DIV / 2 + 2 ||
            last_valid_cyc - byte_start_cyc > 9 * DIV + DIV / 2 + 8) begin
          failures++;
          $display("[TB] FAIL valid_latency actual=%0d required=%0d..%0d cycles",
                   last_valid_cyc - byte_start_cyc, 9 * DIV + DIV / 2 + 2, 9 * DIV + DIV / 2 + 8);
        end
      end
    end

    // Truncated frame: header plus five payload bytes, then silence.
    sendByte(8'hAA, 1'b1);
    sendByte(8'h55, 1'b1);
    for (int i = 1; i <= 5; i++) sendByte(8'(i), 1'b1);
    pushExpect(EV_TIMEOUT);
    waitDrain(50 * DIV);
    applyStimulus('{8'h82, 24'h000AAA, 24'h000BBB, 24'h000CCC, 16'h0DDD, 8'h00, 1'b0, EV_VALID});
    waitDrain(6 * DIV);

    // Framing fault mid-frame must drop back to hunting so the next frame is clean.
    sendByte(8'hAA, 1'b1);
    sendByte(8'h55, 1'b1);
    sendByte(8'h11, 1'b1);
    sendByte(8'h22, 1'b1);
    pushExpect(EV_FRAMING);
    sendByte(8'h00, 1'b0);
    applyStimulus('{8'h84, 24'hF00000, 24'h0F0000, 24'h00F000, 16'h1234, 8'h00, 1'b0, EV_VALID});
    waitDrain(6 * DIV);

    // Reset in the middle of a frame.
    sendByte(8'hAA, 1'b1);
    sendByte(8'h55, 1'b1);
    sendByte(8'h85, 1'b1);
    sendByte(8'h01, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero();
    reset = 1'b0;
    model = '{EV_VALID, 8'd0, 24'd0, 24'd0, 24'd0, 13'd0, 32'd0, 32'd0};
    repeat (2 * DIV) @(negedge clk);
    applyStimulus('{8'h86, 24'h000042, 24'hFFFF00, 24'h000001, 16'h1FFE, 8'h00, 1'b0, EV_VALID});
    waitDrain(6 * DIV);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
